// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the UART system-command decoder: opcodes, parser states,
// fixed operand register addresses and a small byte-qualification helper.
// No logic of its own; imported by the decoder, its interface users and the bench.
package sys_cmd_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // reg write: addr, data
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // reg read: addr
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // ALU with operands: A, B, func
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU without operands: func

    // Register-file slots that receive the ALU operands
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ADDR  = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_ALU_A    = 3'd4,
        ST_ALU_B    = 3'd5,
        ST_ALU_FUNC = 3'd6
    } cmd_state_e;

    // A byte may advance the parser only if it is valid and carries no line error.
    function automatic logic byte_is_clean(input logic vld, input logic par_err, input logic stp_err);
        return vld & ~par_err & ~stp_err;
    endfunction

endpackage

// File: rtl/sys_cmd_decoder_if.sv
// Bundle between the UART receiver and the command decoder outputs.
// master: the byte source (UART Rx side) that also observes decoder outputs.
// slave : the decoder; consumes Rx_* and drives the RF/ALU strobes and frame status.
interface sys_cmd_decoder_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int FUNC_W = 4
);
    logic [WIDTH-1:0]  Rx_data;
    logic              Rx_valid;
    logic              Parity_error;
    logic              stop_error;

    logic              RF_WrEn;
    logic              RF_RdEn;
    logic [ADDR_W-1:0] RF_Address;
    logic [WIDTH-1:0]  RF_WrData;
    logic              ALU_EN;
    logic [FUNC_W-1:0] ALU_FUN;
    logic              frame_done;
    logic              frame_error;
    logic              Busy;

    modport master (
        output Rx_data, Rx_valid, Parity_error, stop_error,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
               frame_done, frame_error, Busy
    );

    modport slave (
        input  Rx_data, Rx_valid, Parity_error, stop_error,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
               frame_done, frame_error, Busy
    );
endinterface

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte timeout counter: counts cycles while a frame is open, clears on every byte.
// Ports: i_clk, i_rst_n (sync, active-low), i_clear (byte seen), i_run (frame open), o_expire.
// o_expire is combinational and high in the cycle whose closing edge makes the count reach TIMEOUT_CYC.
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry is flagged one count early so the parser drops to IDLE on the same
    // edge the count reaches TIMEOUT_CYC; a byte in that cycle does not rescue the frame.
    assign o_expire = i_run && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sys_cmd_decoder.sv
// Parses system command frames from UART Rx bytes into one-cycle RF write/read and ALU strobes.
// Ports: CLK, Reset (sync, active-low), bus (slave modport: Rx_* in; RF_*, ALU_*, frame_*, Busy out).
// All outputs registered, one cycle after the sampling edge; optional inter-byte timeout via CMD_TIMEOUT_EN.
module sys_cmd_decoder
    import sys_cmd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 4,
    parameter int FUNC_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             Reset,
    sys_cmd_decoder_if.slave bus
);
    cmd_state_e        r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_rf_wr_en;
    logic              r_rf_rd_en;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [WIDTH-1:0]  r_rf_wdata;
    logic              r_alu_en;
    logic [FUNC_W-1:0] r_alu_fun;
    logic              r_done;
    logic              r_err;
    logic              r_busy;

    logic              w_expire;
    cmd_state_e        w_state;
    logic              w_clean;
    logic              w_corrupt;
    logic [ADDR_W-1:0] w_lo_addr;
    logic [FUNC_W-1:0] w_lo_fun;

    assign w_clean   = byte_is_clean(bus.Rx_valid, bus.Parity_error, bus.stop_error);
    assign w_corrupt = bus.Rx_valid & (bus.Parity_error | bus.stop_error);
    assign w_lo_addr = bus.Rx_data[ADDR_W-1:0];
    assign w_lo_fun  = bus.Rx_data[FUNC_W-1:0];

`ifdef CMD_TIMEOUT_EN
    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (CLK),
        .i_rst_n  (Reset),
        .i_clear  (bus.Rx_valid),
        .i_run    (r_state != ST_IDLE),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // On timeout the frame is abandoned before the current byte is looked at,
    // so a byte arriving in the expiry cycle is parsed as if the state were IDLE.
    assign w_state = w_expire ? ST_IDLE : r_state;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_wr_addr  <= '0;
            r_rf_wr_en <= 1'b0;
            r_rf_rd_en <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_alu_en   <= 1'b0;
            r_alu_fun  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rf_wr_en <= 1'b0;
            r_rf_rd_en <= 1'b0;
            r_alu_en   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= w_expire;
            r_state    <= w_state;
            r_busy     <= (w_state != ST_IDLE);

            if (w_corrupt) begin
                // Corrupt byte: drop it, abort whatever frame was open.
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (w_clean) begin
                case (w_state)
                    ST_IDLE: begin
                        if (bus.Rx_data == WIDTH'(CMD_RF_WR)) begin
                            r_state <= ST_WR_ADDR;
                            r_busy  <= 1'b1;
                        end else if (bus.Rx_data == WIDTH'(CMD_RF_RD)) begin
                            r_state <= ST_RD_ADDR;
                            r_busy  <= 1'b1;
                        end else if (bus.Rx_data == WIDTH'(CMD_ALU_OP)) begin
                            r_state <= ST_ALU_A;
                            r_busy  <= 1'b1;
                        end else if (bus.Rx_data == WIDTH'(CMD_ALU_NOP)) begin
                            r_state <= ST_ALU_FUNC;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    ST_WR_ADDR: begin
                        // Held privately; RF_Address only moves when a strobe fires.
                        r_wr_addr <= w_lo_addr;
                        r_state   <= ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        r_rf_wr_en <= 1'b1;
                        r_rf_addr  <= r_wr_addr;
                        r_rf_wdata <= bus.Rx_data;
                        r_done     <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                    ST_RD_ADDR: begin
                        r_rf_rd_en <= 1'b1;
                        r_rf_addr  <= w_lo_addr;
                        r_done     <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                    ST_ALU_A: begin
                        r_rf_wr_en <= 1'b1;
                        r_rf_addr  <= ADDR_W'(OPA_ADDR);
                        r_rf_wdata <= bus.Rx_data;
                        r_state    <= ST_ALU_B;
                    end
                    ST_ALU_B: begin
                        r_rf_wr_en <= 1'b1;
                        r_rf_addr  <= ADDR_W'(OPB_ADDR);
                        r_rf_wdata <= bus.Rx_data;
                        r_state    <= ST_ALU_FUNC;
                    end
                    ST_ALU_FUNC: begin
                        r_alu_en  <= 1'b1;
                        r_alu_fun <= w_lo_fun;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.RF_WrEn     = r_rf_wr_en;
    assign bus.RF_RdEn     = r_rf_rd_en;
    assign bus.RF_Address  = r_rf_addr;
    assign bus.RF_WrData   = r_rf_wdata;
    assign bus.ALU_EN      = r_alu_en;
    assign bus.ALU_FUN     = r_alu_fun;
    assign bus.frame_done  = r_done;
    assign bus.frame_error = r_err;
    assign bus.Busy        = r_busy;
endmodule

// File: doc/sys_cmd_decoder.md
# sys_cmd_decoder

Command-frame decoder on the receive side of the UART link. It consumes bytes delivered by the UART receiver, parses the system command protocol and issues one-cycle strobes: register-file writes and reads, and ALU operations. It sits in the Rx clock domain between the UART receiver outputs and the register file / ALU inputs.

## Interface
- WIDTH, 8, byte/data width
- ADDR_W, 4, register-file address width
- FUNC_W, 4, ALU function code width
- TIMEOUT_CYC, 1024, inter-byte timeout in CLK cycles (used only with CMD_TIMEOUT_EN)

- CLK  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-low reset
- Rx_data  in  WIDTH  received byte, qualified by Rx_valid
- Rx_valid  in  1  one-cycle pulse per received byte
- Parity_error  in  1  qualified by Rx_valid; byte is corrupt
- stop_error  in  1  qualified by Rx_valid; byte is corrupt
- RF_WrEn  out  1  one-cycle register-file write strobe
- RF_RdEn  out  1  one-cycle register-file read strobe
- RF_Address  out  ADDR_W  address for RF_WrEn/RF_RdEn
- RF_WrData  out  WIDTH  write data for RF_WrEn
- ALU_EN  out  1  one-cycle ALU start strobe
- ALU_FUN  out  FUNC_W  ALU function, valid with ALU_EN
- frame_done  out  1  one-cycle pulse when a complete frame executes
- frame_error  out  1  one-cycle pulse when a frame is aborted
- Busy  out  1  high while a frame is partially received (state not IDLE)

## Operation
- Opcodes: 0xAA reg write (addr, data); 0xBB reg read (addr); 0xCC ALU with operands (A, B, func); 0xDD ALU without operands (func).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC. Each state advances only on a clean byte (Rx_valid=1, both error flags 0).
- IDLE: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to ALU_A, 0xDD to ALU_FUNC. Any other byte pulses frame_error and stays in IDLE.
- WR_ADDR: latch Rx_data[ADDR_W-1:0]; upper bits are ignored. Go to WR_DATA.
- WR_DATA: RF_WrEn with the latched address and the byte. Pulse frame_done. Go to IDLE.
- RD_ADDR: RF_RdEn with Rx_data[ADDR_W-1:0]. Pulse frame_done. Go to IDLE.
- ALU_A: RF_WrEn, address 0, data = byte. Go to ALU_B.
- ALU_B: RF_WrEn, address 1, data = byte. Go to ALU_FUNC.
- ALU_FUNC: ALU_EN with ALU_FUN = Rx_data[FUNC_W-1:0]. Pulse frame_done. Go to IDLE.
- Corrupt byte (Rx_valid with Parity_error or stop_error) in any state:
  - the byte is discarded and produces no strobe;
  - frame_error pulses and the state returns to IDLE.
- RF_Address, RF_WrData and ALU_FUN hold their last value between strobes.

## Timing
- All outputs are registered. Each strobe, frame_done and frame_error asserts exactly one cycle after the CLK edge that sampled the triggering Rx_valid.
- Back-to-back Rx_valid on consecutive cycles is supported with no byte loss.
- Reset low at any clock edge, including mid-frame:
  - state goes to IDLE and the partial frame is lost;
  - every output goes to 0 on the next edge;
  - no strobe is emitted for the partial frame.
- Busy asserts on the cycle after the opcode is accepted. It deasserts in the same cycle as frame_done or frame_error.

## Configuration
- CMD_TIMEOUT_EN defined:
  - a counter of width $clog2(TIMEOUT_CYC+1) clears on every Rx_valid and counts while the state is not IDLE;
  - when the count reaches TIMEOUT_CYC, state goes to IDLE and frame_error pulses;
  - an Rx_valid arriving in that same cycle is processed in IDLE.
- CMD_TIMEOUT_EN undefined: no counter; a partial frame waits indefinitely.

## Structure
- Package sys_cmd_pkg holds:
  - opcode constants CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP;
  - the state enum;
  - operand register addresses OPA_ADDR=0 and OPB_ADDR=1.
- Optional sub-module cmd_timeout_cnt: counter plus expiry pulse, instantiated only under CMD_TIMEOUT_EN.

## Test plan
- Bytes 0xAA, 0x05, 0x3C -> one cycle after the third Rx_valid: RF_WrEn=1, RF_Address=5, RF_WrData=0x3C, frame_done=1. Busy was high between bytes.
- Bytes 0xBB, 0x0A -> RF_RdEn=1 with RF_Address=0xA; RF_WrEn stays 0.
- Bytes 0xCC, 0x12, 0x34, 0x02 on consecutive cycles -> RF_WrEn addr 0 data 0x12, then RF_WrEn addr 1 data 0x34, then ALU_EN with ALU_FUN=2 and frame_done.
- Bytes 0xDD, 0x07 -> ALU_EN with ALU_FUN=7 and no RF strobe. Opcode 0x55 -> frame_error only, Busy stays 0.
- Bytes 0xAA, 0x05, then 0x3C with Parity_error=1 -> no RF_WrEn, frame_error, return to IDLE. A following 0xBB, 0x01 -> RF_RdEn addr 1. Repeat the sequence with stop_error.
- Reset low during WR_DATA -> all outputs 0, no strobe, IDLE.
- With CMD_TIMEOUT_EN and TIMEOUT_CYC=16: byte 0xAA then silence -> frame_error 16 cycles later, Busy low.
